sy_updn_modcnt: RTL and testbench

Parametrised synchronous up/down modulo counter; the next generation of the team's N-bit synchronous down counter. Adds runtime direction, programmable modulus, parallel load, a combinational terminal-count output for cascading, and a registered wrap pulse. It sits wherever a cascadable timebase, divider or event counter is needed. It is a drop-in for the down counter when `up_dn` is tied to 0 and `MOD = 2**N`.

---
 rtl/sy_updn_modcnt.sv | 80 ++++++++
 tb/tb_sy_updn_modcnt.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sy_updn_modcnt.sv
// Cascadable up/down modulo counter with parallel load and wrap pulse.
// Define SY_UPDN_MODCNT_SAT_EN to saturate at the terminal value instead of wrapping.
module sy_updn_modcnt #(
  parameter int N       = 4,
  parameter int MOD     = 2**N,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap
);

  // N+1 bits so that MOD = 2**N still fits
  localparam logic [N:0]   TOP   = (N+1)'(MOD - 1);
  localparam logic [N-1:0] TOP_Q = TOP[N-1:0];
  localparam logic [N-1:0] RST_Q = N'(RST_VAL);
  localparam logic [N-1:0] ONE   = N'(1);

  logic         at_top;
  logic         at_bot;
  logic         over;
  logic [N-1:0] q_nxt;
  logic         wrap_nxt;

  assign at_top = {1'b0, q} == TOP;
  assign at_bot = q == '0;
  assign over   = {1'b0, q} > TOP;
  assign tc     = enable & (up_dn ? at_top : at_bot);

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = ({1'b0, load_val} > TOP) ? TOP_Q : load_val;
    end else if (enable) begin
      if (over) begin
        q_nxt = '0;
      end else if (up_dn) begin
        if (at_top) begin
`ifdef SY_UPDN_MODCNT_SAT_EN
          q_nxt    = TOP_Q;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q + ONE;
        end
      end else begin
        if (at_bot) begin
`ifdef SY_UPDN_MODCNT_SAT_EN
          q_nxt    = '0;
`else
          q_nxt    = TOP_Q;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_sy_updn_modcnt.sv
// Directed bench for sy_updn_modcnt, N=4 MOD=10 RST_VAL=0.
// Follows SY_UPDN_MODCNT_SAT_EN to pick wrap or saturating expectations.
module tb_sy_updn_modcnt;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  sy_updn_modcnt #(.N(4), .MOD(10), .RST_VAL(0)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .up_dn(up_dn),
    .load(load),
    .load_val(load_val),
    .q(q),
    .tc(tc),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    up_dn = 1'b1;
    load = 1'b0;
    load_val = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold q=%0d wrap=%0b exp q=0 wrap=0", q, wrap);
      end
    end
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_tc tc=%0b exp 0", tc);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (q !== 4'd1) begin
      failures++;
      $display("FAIL reset_first_step q=%0d exp 1", q);
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] eq;
    do_load(4'd0);
    enable = 1'b1;
    up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      eq = 4'(i % 10);
      checks++;
      if (q !== eq || wrap !== (i == 10) || tc !== (eq == 4'd9)) begin
        failures++;
        $display("FAIL up_wrap step%0d q=%0d wrap=%0b tc=%0b exp q=%0d wrap=%0b tc=%0b",
                 i, q, wrap, tc, eq, (i == 10), (eq == 4'd9));
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] dn_q [4];
    logic [3:0] up_q [2];
    dn_q = '{4'd1, 4'd0, 4'd9, 4'd8};
    up_q = '{4'd9, 4'd0};
    do_load(4'd2);
    enable = 1'b1;
    up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== dn_q[i] || wrap !== (i == 2) || tc !== (dn_q[i] == 4'd0)) begin
        failures++;
        $display("FAIL down_wrap step%0d q=%0d wrap=%0b tc=%0b exp q=%0d wrap=%0b tc=%0b",
                 i, q, wrap, tc, dn_q[i], (i == 2), (dn_q[i] == 4'd0));
      end
    end
    up_dn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== up_q[i] || wrap !== (i == 1)) begin
        failures++;
        $display("FAIL dir_change step%0d q=%0d wrap=%0b exp q=%0d wrap=%0b",
                 i, q, wrap, up_q[i], (i == 1));
      end
    end
  endtask

  task automatic test_load();
    enable = 1'b1;
    up_dn = 1'b1;
    load = 1'b1;
    load_val = 4'd5;
    tick();
    checks++;
    if (q !== 4'd5 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load5 q=%0d wrap=%0b exp q=5 wrap=0", q, wrap);
    end
    load_val = 4'd13;
    tick();
    checks++;
    if (q !== 4'd9) begin
      failures++;
      $display("FAIL load_clamp q=%0d exp 9", q);
    end
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL tc_during_load tc=%0b exp 1", tc);
    end
    load_val = 4'd3;
    tick();
    checks++;
    if (q !== 4'd3 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_over_tc q=%0d wrap=%0b exp q=3 wrap=0", q, wrap);
    end
    load_val = 4'd15;
    tick();
    checks++;
    if (q !== 4'd9) begin
      failures++;
      $display("FAIL load_clamp15 q=%0d exp 9", q);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    do_load(4'd6);
    enable = 1'b1;
    up_dn = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset q=%0d wrap=%0b exp q=0 wrap=0", q, wrap);
    end
    #2;
    rst = 1'b1;
    enable = 1'b0;
    up_dn = 1'b0;
    tick();
    tick();
    checks++;
    if (q !== 4'd0) begin
      failures++;
      $display("FAIL hold_zero q=%0d exp 0", q);
    end
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL tc_gated tc=%0b exp 0", tc);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL tc_down_zero tc=%0b exp 1", tc);
    end
    enable = 1'b0;
    do_load(4'd4);
    tick();
    tick();
    checks++;
    if (q !== 4'd4) begin
      failures++;
      $display("FAIL hold_four q=%0d exp 4", q);
    end
  endtask

  task automatic test_sat();
    logic [3:0] eq [5];
    eq = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    do_load(4'd7);
    enable = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q !== eq[i] || wrap !== 1'b0 || tc !== (eq[i] == 4'd9)) begin
        failures++;
        $display("FAIL sat_up step%0d q=%0d wrap=%0b tc=%0b exp q=%0d wrap=0 tc=%0b",
                 i, q, wrap, tc, eq[i], (eq[i] == 4'd9));
      end
    end
    enable = 1'b0;
    do_load(4'd1);
    enable = 1'b1;
    up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0 || tc !== 1'b1) begin
        failures++;
        $display("FAIL sat_down step%0d q=%0d wrap=%0b tc=%0b exp q=0 wrap=0 tc=1",
                 i, q, wrap, tc);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef SY_UPDN_MODCNT_SAT_EN
    test_sat();
`else
    test_up_wrap();
    test_down_wrap();
`endif
    test_load();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
